// File: rtl/pipe_skid_latch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_latch
// Description : One-stage valid/ready pipeline latch with a 1-entry skid buffer,
//               synchronous flush to bubbles and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_latch #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HEAD  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic accept;
    logic drain;

    // Handshake outputs come straight from the state register.
    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = (state_q != S_FULL);
    assign occ       = state_q;
    assign out_data  = head_data_q;
    assign out_ctrl  = out_valid ? head_ctrl_q : '0;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_cnt_d = stall_cnt_q;

        if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d     = S_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA != 0) begin
                head_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d     = S_HEAD;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                S_HEAD: begin
                    if (accept && !drain) begin
                        state_d     = S_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (accept && drain) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        state_d     = S_HEAD;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_latch
// Description : Self-checking bench: directed table, corner sequences and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_latch;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready_a,  out_valid_a;
    logic [31:0] out_data_a;
    logic [7:0]  out_ctrl_a;
    logic [1:0]  occ_a;
    logic [15:0] stall_cnt_a;

    logic        in_ready_b,  out_valid_b;
    logic [31:0] out_data_b;
    logic [7:0]  out_ctrl_b;
    logic [1:0]  occ_b;
    logic [3:0]  stall_cnt_b;

    int n_chk;
    int n_fail;

    // Instance A clears data on flush; instance B keeps data and has a 4-bit counter.
    pipe_skid_latch #(.DATA_W(32), .CTRL_W(8), .CLR_DATA(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .occ(occ_a), .stall_cnt(stall_cnt_a)
    );

    pipe_skid_latch #(.DATA_W(32), .CTRL_W(8), .CLR_DATA(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .occ(occ_b), .stall_cnt(stall_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic [1:0]  eocc;
        logic        evalid;
        logic [31:0] edata;
        logic        erdy;
    } vec_t;

    vec_t tbl [17];

    // Reference model state: FIFO contents as {ctrl, data}, saturating stall counts.
    logic [39:0] mq [$];
    int          m_cnt_a;
    int          m_cnt_b;

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return d[7:0] ^ 8'h3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                         input logic [7:0] c, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both_reset(input string tag);
        chk({tag, " occ_a"},       32'(occ_a),       32'd0);
        chk({tag, " out_valid_a"}, 32'(out_valid_a), 32'd0);
        chk({tag, " in_ready_a"},  32'(in_ready_a),  32'd1);
        chk({tag, " out_ctrl_a"},  32'(out_ctrl_a),  32'd0);
        chk({tag, " out_data_a"},  out_data_a,       32'd0);
        chk({tag, " stall_cnt_a"}, 32'(stall_cnt_a), 32'd0);
        chk({tag, " occ_b"},       32'(occ_b),       32'd0);
        chk({tag, " out_valid_b"}, 32'(out_valid_b), 32'd0);
        chk({tag, " out_ctrl_b"},  32'(out_ctrl_b),  32'd0);
        chk({tag, " stall_cnt_b"}, 32'(stall_cnt_b), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        step();
        step();
        chk_both_reset("reset");
        rst_n = 1'b1;

        // Streaming 1..8, drain, skid sequence, then flush while FULL.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b0, 1'b1, 32'(i + 1), 1'b1, 2'd1, 1'b1, 32'(i + 1), 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0,  1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'hA,  1'b0, 2'd1, 1'b1, 32'hA,  1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'hB,  1'b0, 2'd2, 1'b1, 32'hA,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1, 32'hB,  1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0,  1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'hA,  1'b0, 2'd1, 1'b1, 32'hA,  1'b1};
        tbl[14] = '{1'b0, 1'b1, 32'hB,  1'b0, 2'd2, 1'b1, 32'hA,  1'b0};
        tbl[15] = '{1'b1, 1'b1, 32'hC,  1'b0, 2'd0, 1'b0, 32'h0,  1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0,  1'b1};

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].din, ctrl_of(tbl[i].din), tbl[i].ordy);
            step();
            chk($sformatf("tbl%0d occ_a", i),       32'(occ_a),       32'(tbl[i].eocc));
            chk($sformatf("tbl%0d occ_b", i),       32'(occ_b),       32'(tbl[i].eocc));
            chk($sformatf("tbl%0d out_valid_a", i), 32'(out_valid_a), 32'(tbl[i].evalid));
            chk($sformatf("tbl%0d in_ready_a", i),  32'(in_ready_a),  32'(tbl[i].erdy));
            chk($sformatf("tbl%0d in_ready_b", i),  32'(in_ready_b),  32'(tbl[i].erdy));
            chk($sformatf("tbl%0d out_ctrl_a", i),  32'(out_ctrl_a),
                tbl[i].evalid ? 32'(ctrl_of(tbl[i].edata)) : 32'd0);
            chk($sformatf("tbl%0d out_ctrl_b", i),  32'(out_ctrl_b),
                tbl[i].evalid ? 32'(ctrl_of(tbl[i].edata)) : 32'd0);
            if (tbl[i].evalid) begin
                chk($sformatf("tbl%0d out_data_a", i), out_data_a, tbl[i].edata);
                chk($sformatf("tbl%0d out_data_b", i), out_data_b, tbl[i].edata);
            end
            if (i == 12) chk("skid stall_cnt_a", 32'(stall_cnt_a), 32'd1);
            if (i == 15) begin
                chk("flush clr out_data_a",  out_data_a, 32'h0);
                chk("flush keep out_data_b", out_data_b, 32'hA);
            end
        end
        chk("flush stall_cnt_a", 32'(stall_cnt_a), 32'd3);

        // Saturation: one entry held under stall for 20 cycles.
        drive(1'b0, 1'b1, 32'hD, ctrl_of(32'hD), 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall hold out_data_a", out_data_a, 32'hD);
        end
        chk("sat stall_cnt_b", 32'(stall_cnt_b), 32'd15);
        chk("sat stall_cnt_a", 32'(stall_cnt_a), 32'd23);

        // Reset asserted while FULL takes effect without a clock edge.
        drive(1'b1, 1'b0, 32'h0, 8'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h11, ctrl_of(32'h11), 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h22, ctrl_of(32'h22), 1'b0);
        step();
        chk("prefill occ_a", 32'(occ_a), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_both_reset("async reset");
        step();
        rst_n = 1'b1;

        // Randomized run against the queue model.
        mq.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        fl, iv, ordy, acc, drn;
            logic [31:0] d;
            logic [7:0]  c;
            fl   = ($urandom_range(0, 63) == 0);
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 50);
            d    = $urandom;
            c    = 8'($urandom);
            drive(fl, iv, d, c, ordy);
            acc = iv && (mq.size() < 2) && !fl;
            drn = (mq.size() > 0) && ordy;
            if (mq.size() > 0 && !ordy) begin
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 15)    m_cnt_b++;
            end
            step();
            if (fl) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back({c, d});
            end
            chk("rnd occ_a",       32'(occ_a),       32'(mq.size()));
            chk("rnd occ_b",       32'(occ_b),       32'(mq.size()));
            chk("rnd in_ready_a",  32'(in_ready_a),  32'(mq.size() < 2));
            chk("rnd out_valid_a", 32'(out_valid_a), 32'(mq.size() > 0));
            chk("rnd out_ctrl_a",  32'(out_ctrl_a),  mq.size() > 0 ? 32'(mq[0][39:32]) : 32'd0);
            chk("rnd out_ctrl_b",  32'(out_ctrl_b),  mq.size() > 0 ? 32'(mq[0][39:32]) : 32'd0);
            if (mq.size() > 0) begin
                chk("rnd out_data_a", out_data_a, mq[0][31:0]);
                chk("rnd out_data_b", out_data_b, mq[0][31:0]);
            end
            chk("rnd stall_cnt_a", 32'(stall_cnt_a), 32'(m_cnt_a));
            chk("rnd stall_cnt_b", 32'(stall_cnt_b), 32'(m_cnt_b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
